// File: rtl/ps2_dev_emu.sv
// PS/2 device-side emulator: sends bytes to the host, accepts host
// request-to-send commands, and optionally answers them automatically.
module ps2_dev_emu #(
  parameter int unsigned CLK_HALF    = 2000,
  parameter int unsigned INHIBIT_MIN = 5000,
  parameter int unsigned AUTO_REPLY  = 1
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_drv,
  output logic       ps2_data_drv,
  input  logic       tx_vld,
  input  logic [7:0] tx_data,
  output logic       tx_rdy,
  output logic       rx_vld,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       busy
);

  localparam int unsigned IDLE_MIN = 2 * CLK_HALF;
  localparam int unsigned CMAX     = (IDLE_MIN > INHIBIT_MIN) ? IDLE_MIN : INHIBIT_MIN;
  localparam int unsigned CW       = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] IDLE_SAT  = CW'(IDLE_MIN);
  localparam logic [CW-1:0] INH_SAT   = CW'(INHIBIT_MIN);
  // Our own clock release needs the synchronizer latency to show up on
  // the sampled line before a low level can be blamed on the host.
  localparam logic [CW-1:0] GUARD     = CW'(3);

  typedef enum logic [2:0] {IDLE, TX, RX_WAIT, RX, RX_ACK} state_t;

  state_t        state_q, state_d;
  logic          clk_meta_q, clk_s_q, dat_meta_q, dat_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;          // 1 = clock-low half of a pulse
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]    txb_q, txb_d;
  logic          txsrc_q, txsrc_d;          // 1 = byte came from reply queue
  logic [7:0]    hbuf_q, hbuf_d;
  logic          hpend_q, hpend_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [7:0]    q_mem_q [3];
  logic [7:0]    q_mem_d [3];
  logic [1:0]    q_cnt_q, q_cnt_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_err_q, rx_err_d;

  logic          idle_ok, half_done, rx_good;
  logic [10:0]   tx_frame;

  assign idle_ok   = (idle_cnt_q == IDLE_SAT);
  assign half_done = (cnt_q == HALF_LAST);
  assign tx_frame  = {1'b1, ~^txb_q, txb_q, 1'b0};
  assign rx_good   = (^shreg_q[8:0]) & shreg_q[9];

  // Two-flop synchronizers for the open-drain bus lines (idle level high).
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      clk_meta_q <= 1'b1;
      clk_s_q    <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_s_q    <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_s_q    <= clk_meta_q;
      dat_meta_q <= ps2_data_i;
      dat_s_q    <= dat_meta_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      idle_cnt_q <= '0;
      low_cnt_q  <= '0;
      txb_q      <= '0;
      txsrc_q    <= 1'b0;
      hbuf_q     <= '0;
      hpend_q    <= 1'b0;
      shreg_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) q_mem_q[i] <= '0;
      q_cnt_q    <= '0;
      rx_data_q  <= '0;
      rx_vld_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      idle_cnt_q <= idle_cnt_d;
      low_cnt_q  <= low_cnt_d;
      txb_q      <= txb_d;
      txsrc_q    <= txsrc_d;
      hbuf_q     <= hbuf_d;
      hpend_q    <= hpend_d;
      shreg_q    <= shreg_d;
      q_mem_q    <= q_mem_d;
      q_cnt_q    <= q_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_vld_q   <= rx_vld_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Next-state logic: line qualification counters, frame sequencing, reply queue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    txb_d     = txb_q;
    txsrc_d   = txsrc_q;
    hbuf_d    = hbuf_q;
    hpend_d   = hpend_q;
    shreg_d   = shreg_q;
    q_mem_d   = q_mem_q;
    q_cnt_d   = q_cnt_q;
    rx_data_d = rx_data_q;
    rx_vld_d  = 1'b0;
    rx_err_d  = 1'b0;

    if (clk_s_q && dat_s_q) idle_cnt_d = idle_ok ? idle_cnt_q : idle_cnt_q + 1'b1;
    else                    idle_cnt_d = '0;

    if (!clk_s_q) low_cnt_d = (low_cnt_q == INH_SAT) ? low_cnt_q : low_cnt_q + 1'b1;
    else          low_cnt_d = '0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        if (clk_s_q && (low_cnt_q == INH_SAT) && !dat_s_q) begin
          state_d = RX_WAIT;
        end else if (idle_ok && (q_cnt_q != 2'd0)) begin
          txb_d   = q_mem_q[0];
          txsrc_d = 1'b1;
          state_d = TX;
        end else if (idle_ok && hpend_q) begin
          txb_d   = hbuf_q;
          txsrc_d = 1'b0;
          state_d = TX;
        end else if (tx_vld && tx_rdy) begin
          hbuf_d  = tx_data;
          hpend_d = 1'b1;
        end
      end

      TX: begin
        // Source byte is only retired on completion, so an abort simply
        // returns to IDLE and the same byte is picked up again.
        if (!phase_q && (bit_q != 4'd10) && !clk_s_q && (cnt_q >= GUARD)) begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else if (!half_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == 4'd10) begin
              state_d = IDLE;
              bit_d   = '0;
              if (txsrc_q) begin
                q_mem_d[0] = q_mem_q[1];
                q_mem_d[1] = q_mem_q[2];
                q_mem_d[2] = '0;
                q_cnt_d    = q_cnt_q - 2'd1;
              end else begin
                hpend_d = 1'b0;
              end
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end

      RX_WAIT: begin
        if (!half_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = RX;
        end
      end

      RX: begin
        if (!half_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (!phase_q) begin
            shreg_d = {dat_s_q, shreg_q[9:1]};
          end else if (bit_q == 4'd9) begin
            bit_d   = '0;
            state_d = RX_ACK;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      RX_ACK: begin
        if (!half_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            state_d = IDLE;
            if (rx_good) begin
              rx_vld_d  = 1'b1;
              rx_data_d = shreg_q[7:0];
            end else begin
              rx_err_d = 1'b1;
            end
            if (AUTO_REPLY != 0) begin
              q_mem_d[1] = '0;
              q_mem_d[2] = '0;
              if (!rx_good) begin
                q_mem_d[0] = 8'hFE;
                q_cnt_d    = 2'd1;
              end else if (shreg_q[7:0] == 8'hFF) begin
                q_mem_d[0] = 8'hFA;
                q_mem_d[1] = 8'hAA;
                q_mem_d[2] = 8'h00;
                q_cnt_d    = 2'd3;
              end else begin
                q_mem_d[0] = 8'hFA;
                q_cnt_d    = 2'd1;
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Bus drivers and status outputs decoded from the registered state.
  always_comb begin
    ps2_clk_drv  = 1'b0;
    ps2_data_drv = 1'b0;
    if (state_q == TX) begin
      ps2_clk_drv  = phase_q;
      ps2_data_drv = ~tx_frame[bit_q];
    end else if (state_q == RX) begin
      ps2_clk_drv  = phase_q;
    end else if (state_q == RX_ACK) begin
      ps2_clk_drv  = phase_q;
      ps2_data_drv = 1'b1;
    end
  end

  assign tx_rdy  = (state_q == IDLE) && (q_cnt_q == 2'd0) && !hpend_q && idle_ok;
  assign busy    = (state_q != IDLE);
  assign rx_vld  = rx_vld_q;
  assign rx_err  = rx_err_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_ps2_dev_emu.sv
// Bench for ps2_dev_emu: open-drain bus model, host-side frame encoder/decoder
// and a reply model derived from the command rules.
module tb_ps2_dev_emu;

  localparam int unsigned HALF = 20;
  localparam int unsigned INH  = 50;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       host_clk_low  = 1'b0;
  logic       host_data_low = 1'b0;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_drv, ps2_data_drv;
  logic       tx_vld, tx_rdy, rx_vld, rx_err, busy;
  logic [7:0] tx_data, rx_data;

  assign ps2_clk_i  = ~(ps2_clk_drv  | host_clk_low);
  assign ps2_data_i = ~(ps2_data_drv | host_data_low);

  always #5 clk_sys = ~clk_sys;

  ps2_dev_emu #(.CLK_HALF(HALF), .INHIBIT_MIN(INH), .AUTO_REPLY(1)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_drv(ps2_clk_drv), .ps2_data_drv(ps2_data_drv),
    .tx_vld(tx_vld), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .rx_vld(rx_vld), .rx_data(rx_data), .rx_err(rx_err), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Background pulse / handshake observers
  int vld_cycles = 0;
  int err_cycles = 0;
  int rdy_bad    = 0;
  bit watch_rdy  = 1'b0;
  always @(negedge clk_sys) begin
    if (rx_vld === 1'b1) vld_cycles++;
    if (rx_err === 1'b1) err_cycles++;
    if (watch_rdy && tx_rdy === 1'b1) rdy_bad++;
  end

  // Reference model
  logic [7:0] exp_q[$];

  function automatic logic odd_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic void expect_replies(input logic [7:0] cmd, input bit bad);
    exp_q.delete();
    if (bad)               exp_q.push_back(8'hFE);
    else if (cmd == 8'hFF) begin exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00); end
    else                   exp_q.push_back(8'hFA);
  endfunction

  task automatic wait_fall(output bit ok, input int budget);
    logic prev;
    prev = ps2_clk_i;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (prev === 1'b1 && ps2_clk_i === 1'b0) begin ok = 1'b1; break; end
      prev = ps2_clk_i;
    end
  endtask

  // Decode one device-to-host frame; data is read as the clock falls.
  task automatic recv_frame(input string tag, output logic [7:0] b);
    logic [10:0] bits;
    bit ok;
    int low_bad = 0;
    int lowlen;
    b = '0;
    bits = '0;
    for (int k = 0; k < 11; k++) begin
      wait_fall(ok, (k == 0) ? 3000 : 4 * HALF);
      if (!ok) begin
        chk({tag, "/timeout"}, 32'(k), 32'd11);
        return;
      end
      bits[k] = ps2_data_i;
      lowlen = 1;
      forever begin
        @(negedge clk_sys);
        if (ps2_clk_i !== 1'b0 || lowlen > int'(4 * HALF)) break;
        lowlen++;
      end
      if (lowlen != int'(HALF)) low_bad++;
    end
    chk({tag, "/start"},  32'(bits[0]), 32'd0);
    chk({tag, "/parity"}, 32'(bits[9]), 32'(odd_par(bits[8:1])));
    chk({tag, "/stop"},   32'(bits[10]), 32'd1);
    chk({tag, "/lowlen"}, 32'(low_bad), 32'd0);
    b = bits[8:1];
  endtask

  task automatic tx_send(input logic [7:0] b);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_sys);
      if (tx_rdy === 1'b1) begin ok = 1'b1; break; end
    end
    chk("tx_rdy_wait", 32'(ok), 32'd1);
    tx_data = b;
    tx_vld  = 1'b1;
    @(posedge clk_sys);
    #1 tx_vld = 1'b0;
  endtask

  task automatic check_replies(input string tag);
    logic [7:0] got;
    for (int i = 0; i < exp_q.size(); i++) begin
      recv_frame($sformatf("%s/reply%0d", tag, i), got);
      chk($sformatf("%s/reply%0d_byte", tag, i), 32'(got), 32'(exp_q[i]));
    end
  endtask

  task automatic host_rts();
    host_clk_low = 1'b1;
    repeat (INH + 10) @(negedge clk_sys);
    host_data_low = 1'b1;
    repeat (5) @(negedge clk_sys);
    host_clk_low = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  // Host-to-device command: RTS, bits changed while the clock is low, ACK check.
  task automatic host_send(input logic [7:0] cmd, input bit bad_par, input string tag);
    logic [9:0] fr;
    bit ok;
    int v0 = vld_cycles;
    int e0 = err_cycles;
    fr = {1'b1, odd_par(cmd) ^ bad_par, cmd};
    host_rts();
    host_data_low = ~fr[0];
    for (int k = 1; k <= 10; k++) begin
      wait_fall(ok, 6 * HALF);
      if (!ok) begin
        chk({tag, "/host_clk_timeout"}, 32'(k), 32'd0);
        host_data_low = 1'b0;
        return;
      end
      if (k <= 9) begin
        repeat (3) @(negedge clk_sys);
        host_data_low = ~fr[k];
      end
    end
    wait_fall(ok, 6 * HALF);
    chk({tag, "/ack_clock"}, 32'(ok), 32'd1);
    chk({tag, "/ack_low"},   32'(ps2_data_i), 32'd0);
    for (int i = 0; i < 4 * HALF; i++) begin
      @(negedge clk_sys);
      if (vld_cycles != v0 || err_cycles != e0) break;
    end
    repeat (5) @(negedge clk_sys);
    chk({tag, "/vld_pulses"}, 32'(vld_cycles - v0), bad_par ? 32'd0 : 32'd1);
    chk({tag, "/err_pulses"}, 32'(err_cycles - e0), bad_par ? 32'd1 : 32'd0);
  endtask

  initial begin
    #(10 * 80000);
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] b, got, cmd, prev_rx;
    bit ok;
    int n;

    rst = 1'b1;
    tx_vld = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", {ps2_clk_drv, ps2_data_drv, tx_rdy, rx_vld, rx_err, busy, rx_data}, '0);

    @(posedge clk_sys);
    #1 rst = 1'b0;
    n = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_sys);
      n++;
      if (tx_rdy === 1'b1) break;
    end
    chk("rdy_not_early", 32'(n >= int'(2 * HALF)), 32'd1);
    chk("rdy_not_late",  32'(n <= int'(2 * HALF) + 4), 32'd1);

    // Known frame, tx_rdy must stay low for its whole duration
    tx_send(8'h5A);
    rdy_bad = 0;
    watch_rdy = 1'b1;
    recv_frame("tx5A", got);
    watch_rdy = 1'b0;
    chk("tx5A/byte", 32'(got), 32'h5A);
    chk("tx5A/rdy_low", 32'(rdy_bad), 32'd0);

    for (int t = 0; t < 4; t++) begin
      b = 8'($urandom);
      tx_send(b);
      recv_frame($sformatf("txrnd%0d", t), got);
      chk($sformatf("txrnd%0d/byte", t), 32'(got), 32'(b));
    end

    host_send(8'hF4, 1'b0, "cmdF4");
    chk("cmdF4/rx_data", 32'(rx_data), 32'hF4);
    expect_replies(8'hF4, 1'b0);
    check_replies("cmdF4");

    for (int t = 0; t < 3; t++) begin
      cmd = 8'($urandom);
      host_send(cmd, 1'b0, $sformatf("cmdrnd%0d", t));
      chk($sformatf("cmdrnd%0d/rx_data", t), 32'(rx_data), 32'(cmd));
      expect_replies(cmd, 1'b0);
      check_replies($sformatf("cmdrnd%0d", t));
    end

    // Reset command with a host byte held waiting behind the reply queue
    host_send(8'hFF, 1'b0, "cmdFF");
    chk("cmdFF/rx_data", 32'(rx_data), 32'hFF);
    expect_replies(8'hFF, 1'b0);
    b = 8'($urandom);
    tx_data = b;
    tx_vld = 1'b1;
    rdy_bad = 0;
    watch_rdy = 1'b1;
    check_replies("cmdFF");
    watch_rdy = 1'b0;
    chk("cmdFF/rdy_held_low", 32'(rdy_bad), 32'd0);
    tx_send(b);
    recv_frame("held", got);
    chk("held/byte", 32'(got), 32'(b));

    // Bad parity: error pulse, rx_data unchanged, FE reply
    prev_rx = rx_data;
    host_send(8'h01, 1'b1, "bad01");
    chk("bad01/rx_data_hold", 32'(rx_data), 32'(prev_rx));
    expect_replies(8'h01, 1'b1);
    check_replies("bad01");

    // Host inhibit during bit 4 of 0x33
    tx_send(8'h33);
    for (int k = 0; k < 5; k++) begin
      wait_fall(ok, 3000);
      if (!ok) break;
    end
    chk("abort/reach_bit4", 32'(ok), 32'd1);
    for (int i = 0; i < 4 * HALF; i++) begin
      if (ps2_clk_i === 1'b1) break;
      @(negedge clk_sys);
    end
    repeat (5) @(negedge clk_sys);
    host_clk_low = 1'b1;
    repeat (6) @(negedge clk_sys);
    chk("abort/released", {ps2_clk_drv, ps2_data_drv, busy, tx_rdy}, '0);
    repeat ((3 * INH) / 2 - 6) @(negedge clk_sys);
    host_clk_low = 1'b0;
    recv_frame("resend33", got);
    chk("resend33/byte", 32'(got), 32'h33);
    wait_fall(ok, 300);
    chk("resend33/once", 32'(ok), 32'd0);

    // Reset while a command is being clocked in
    n = vld_cycles;
    host_rts();
    host_data_low = 1'b0;
    for (int k = 0; k < 4; k++) wait_fall(ok, 6 * HALF);
    chk("rstrx/in_rx", 32'(busy), 32'd1);
    @(posedge clk_sys);
    #1 rst = 1'b1;
    @(negedge clk_sys);
    chk("rstrx/outputs", {ps2_clk_drv, ps2_data_drv, tx_rdy, rx_vld, rx_err, busy, rx_data}, '0);
    repeat (3) @(negedge clk_sys);
    @(posedge clk_sys);
    #1 rst = 1'b0;
    wait_fall(ok, 300);
    chk("rstrx/no_frame", 32'(ok), 32'd0);
    chk("rstrx/no_vld", 32'(vld_cycles - n), 32'd0);
    chk("rstrx/queue_empty_rdy", 32'(tx_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_dev_emu.md
PS2_DEV_EMU -- requirements
Module: ps2_dev_emu

Interface
REQ-001 SHALL have parameter CLK_HALF, default 2000, giving the PS/2 clock half-period in clk_sys cycles (12.5 kHz at 50 MHz).
REQ-002 SHALL have parameter INHIBIT_MIN, default 5000, giving the minimum host clock-low time in cycles (100 us) that qualifies a request-to-send.
REQ-003 SHALL have parameter AUTO_REPLY, default 1, where 1 enables automatic command responses.
REQ-004 clk_sys  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ps2_clk_i  in  1  PS2_CLK line level, asynchronous.
REQ-007 ps2_data_i  in  1  PS2_DATA line level, asynchronous.
REQ-008 ps2_clk_drv  out  1  1 = pull PS2_CLK low, 0 = release.
REQ-009 ps2_data_drv  out  1  1 = pull PS2_DATA low, 0 = release.
REQ-010 tx_vld, tx_data[7:0]  in  1/8  byte to send to host.
REQ-011 tx_rdy  out  1  byte accepted when tx_vld&&tx_rdy.
REQ-012 rx_vld, rx_data[7:0]  out  1/8  one-cycle pulse with the received host command.
REQ-013 rx_err  out  1  one-cycle pulse on a received-frame parity or stop error.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 ps2_clk_i and ps2_data_i SHALL pass through a 2-flop synchronizer; all decisions use the synchronized values.
REQ-016 States SHALL be IDLE, TX, RX_WAIT, RX, RX_ACK.
REQ-017 TX frame SHALL be 11 bits: start 0, D0..D7 LSB first, odd parity, stop 1; ps2_data_drv = ~bit.
REQ-018 Per TX bit, data SHALL be set at the start of a CLK_HALF high phase, followed by CLK_HALF of clk_drv=1; frame length = 22*CLK_HALF cycles.
REQ-019 TX SHALL start only from IDLE after both lines have been high for at least 2*CLK_HALF consecutive cycles.
REQ-020 Inhibit: if ps2_clk_i is low while clk_drv=0 during bits 0..9, TX SHALL abort, release both lines within 1 cycle, retain the byte, and retransmit it from the start bit once REQ-019 holds again; during bit 10, TX SHALL complete.
REQ-021 tx_rdy SHALL be 1 only in IDLE with the reply queue empty; an accepted byte is transmitted once, and tx_rdy drops the cycle after acceptance.
REQ-022 Request-to-send: in IDLE or an aborted TX, clk low ≥ INHIBIT_MIN cycles, then clk high with data low, SHALL enter RX_WAIT; clk high with data high returns to IDLE.
REQ-023 RX_WAIT SHALL wait CLK_HALF cycles, then RX generates clock pulses with the same timing as TX, sampling data at each low→high clk_drv transition for D0..D7, parity, stop.
REQ-024 After the stop sample, RX_ACK SHALL drive data_drv=1 for one full clock pulse, then release both lines and return to IDLE.
REQ-025 Good frame (odd parity OK, stop=1): rx_vld SHALL pulse at the end of RX_ACK with rx_data.
REQ-026 Bad frame: rx_err SHALL pulse instead of rx_vld; ACK is still driven.
REQ-027 If AUTO_REPLY=1, a 3-entry reply queue SHALL load as follows: 0xFF→FA,AA,00; bad frame→FE; any other byte→FA.
REQ-028 A new command SHALL flush any unsent queue contents before loading.
REQ-029 Queue entries SHALL have priority over tx_vld; the queue drains in order.
REQ-030 rx_data SHALL hold its value until the next rx_vld.

Reset
REQ-031 rst asserted SHALL immediately force IDLE, clk_drv=0, data_drv=0, tx_rdy=0, rx_vld=0, rx_err=0, busy=0, rx_data=0x00, queue empty, counters 0; a frame in flight is discarded.
REQ-032 tx_rdy SHALL rise only after the REQ-019 idle qualification following reset release.

Verification
REQ-033 tx 0x5A with lines idle → frame 0,0,1,0,1,1,0,1,0,1(parity),1, with clk low phases of 2000 cycles; tx_rdy=0 until the frame completes.
REQ-034 Host RTS sends 0xF4 → rx_vld with rx_data=0xF4, ACK low on clock 11, then a 0xFA frame is sent automatically.
REQ-035 Host RTS sends 0xFF → reply bytes FA, AA, 00 in order; tx_vld is held with tx_rdy=0 until the third byte completes.
REQ-036 Host sends 0x01 with bad parity → rx_err pulse, no rx_vld, reply 0xFE.
REQ-037 Host holds clk low 150 us during bit 4 of a 0x33 frame → abort, lines released, 0x33 resent in full after release.
REQ-038 rst asserted mid-RX → all outputs at reset values next cycle, no rx_vld, and the queue is empty.
